axi_slave_mem: RTL



---
 rtl/axi_slave_mem.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_mem.sv
// axi_slave_mem
//   AXI4 slave memory responder. INCR write bursts land in an internal
//   word-addressed RAM and INCR read bursts are served back from it. The
//   write and read channels are independent, each with one outstanding
//   transaction. Beats 16 bytes wide; addr[3:0] is ignored.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   aw*  (awid/awaddr/awlen)       write address channel
//   w*   (wdata/wstrb/wlast)       write data channel
//   b*   (bid/bresp)               write response channel
//   ar*  (arid/araddr/arlen)       read address channel
//   r*   (rid/rdata/rresp/rlast)   read data channel
//   wr_beat_count, rd_beat_count   accepted W beats / delivered R beats (wrap)
//
// Write FSM
//   state  | meaning
//   W_RST  | held in reset; awready low until first clean edge
//   W_IDLE | awready high, waiting for AW
//   W_DATA | wready high, taking beats 0..awlen
//   W_RESP | bvalid high, waiting for bready
//
// Read FSM
//   state   | meaning
//   R_RST   | held in reset; arready low until first clean edge
//   R_IDLE  | arready high, waiting for AR
//   R_FETCH | synchronous RAM read of the current word
//   R_DATA  | rvalid high, beat held stable until rready

module axi_slave_mem #(
  parameter int unsigned           DATA_WIDTH = 128,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MEM_WORDS  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,

  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,

  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,

  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,

  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,

  output logic [31:0]             wr_beat_count,
  output logic [31:0]             rd_beat_count
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // One bit wider than the word index so a burst of up to 256 beats starting
  // anywhere can run past the top of the address space without wrapping back
  // into the RAM.
  localparam int IDX_WIDTH  = ADDR_WIDTH - 3;
  localparam int RAM_AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [IDX_WIDTH-1:0] MEM_LIMIT = IDX_WIDTH'(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Offset is taken modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR become
  // huge indices and fall out of range naturally.
  function automatic logic [IDX_WIDTH-1:0] addr_to_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return {1'b0, off[ADDR_WIDTH-1:4]};
  endfunction

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {W_RST, W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [IDX_WIDTH-1:0]  w_idx;
  logic [7:0]            w_len;
  logic [7:0]            w_beat;
  logic                  w_err;
  logic                  w_oor;
  logic                  w_final;
  logic                  aw_hs;
  logic                  w_hs;

  assign w_oor   = (w_idx >= MEM_LIMIT);
  assign w_final = (w_beat == w_len);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_RST;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_RST:  w_next = W_IDLE;
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      // Burst ends on the beat count alone; wlast only feeds the error flag.
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id          <= '0;
      w_idx         <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_err         <= 1'b0;
      wr_beat_count <= '0;
    end else begin
      if (aw_hs) begin
        w_id   <= awid;
        w_idx  <= addr_to_idx(awaddr);
        w_len  <= awlen;
        w_beat <= '0;
        w_err  <= 1'b0;
      end
      if (w_hs) begin
        w_idx         <= w_idx + IDX_WIDTH'(1);
        w_beat        <= w_beat + 8'd1;
        wr_beat_count <= wr_beat_count + 32'd1;
        if (w_oor || (wlast != w_final)) w_err <= 1'b1;
      end
    end
  end

  assign bid   = bvalid ? w_id : '0;
  assign bresp = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {R_RST, R_IDLE, R_FETCH, R_DATA} r_state_t;

  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic                  r_oor;
  logic                  r_final;
  logic                  r_fetch;
  logic                  ar_hs;
  logic                  r_hs;

  assign r_oor   = (r_idx >= MEM_LIMIT);
  assign r_final = (r_beat == r_len);
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_RST;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    r_fetch = 1'b0;
    case (r_state)
      R_RST:  r_next = R_IDLE;
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_FETCH;
      end
      R_FETCH: begin
        r_fetch = 1'b1;
        r_next  = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) r_next = r_final ? R_IDLE : R_FETCH;
      end
      default: r_next = R_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id          <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      rd_beat_count <= '0;
    end else begin
      if (ar_hs) begin
        r_id   <= arid;
        r_idx  <= addr_to_idx(araddr);
        r_len  <= arlen;
        r_beat <= '0;
      end
      if (r_hs) begin
        rd_beat_count <= rd_beat_count + 32'd1;
        if (!r_final) begin
          r_idx  <= r_idx + IDX_WIDTH'(1);
          r_beat <= r_beat + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // RAM: byte-strobed write, registered read. Both use non-blocking updates
  // on the same edge, so a same-word read and write returns the old word.
  // Contents are deliberately left out of reset.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [RAM_AW-1:0]     w_addr;
  logic [RAM_AW-1:0]     r_addr;

  assign w_addr = w_idx[RAM_AW-1:0];
  assign r_addr = r_idx[RAM_AW-1:0];

  always_ff @(posedge clk) begin
    // rst gates the write so a beat presented on the aborting edge is dropped.
    if (w_hs && !w_oor && !rst) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[w_addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (r_fetch && !r_oor) ram_q <= mem[r_addr];
  end

  assign rid   = rvalid ? r_id : '0;
  assign rdata = (rvalid && !r_oor) ? ram_q : '0;
  assign rresp = (rvalid && r_oor) ? RESP_SLVERR : RESP_OKAY;
  assign rlast = rvalid && r_final;

endmodule
